// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 3-stage pipeline controller: RV32I opcodes, FSM states
// and opcode classification helpers.
package pipe_ctrl_pkg;

  typedef enum logic [6:0] {
    LOAD    = 7'b0000011,
    STORE   = 7'b0100011,
    BRANCH  = 7'b1100011,
    JAL     = 7'b1101111,
    JALR    = 7'b1100111,
    ALU_REG = 7'b0110011,
    ALU_IMM = 7'b0010011,
    LUI     = 7'b0110111,
    AUIPC   = 7'b0010111
  } opcode_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } pipe_state_e;

  function automatic logic is_writer(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, LOAD, ALU_IMM, ALU_REG: is_writer = 1'b1;
      default:                                      is_writer = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decoder/pipeline-side signals of the hazard controller. The controller
// uses the slave modport; the pipeline datapath uses the master modport.
interface pipe_ctrl_if;
  logic       id_valid_i;
  logic [6:0] id_op_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] id_rd_i;
  logic       br_taken_i;
  logic       dmem_ready_i;

  logic       stall_o;
  logic       flush_o;
  logic       pc_sel_o;
  logic       fwd_rs1_o;
  logic       fwd_rs2_o;
  logic       dmem_req_o;
  logic       wb_we_o;
  logic [4:0] wb_rd_o;

  modport master (
    output id_valid_i, id_op_i, id_rs1_i, id_rs2_i, id_rd_i, br_taken_i, dmem_ready_i,
    input  stall_o, flush_o, pc_sel_o, fwd_rs1_o, fwd_rs2_o, dmem_req_o, wb_we_o, wb_rd_o
  );

  modport slave (
    input  id_valid_i, id_op_i, id_rs1_i, id_rs2_i, id_rd_i, br_taken_i, dmem_ready_i,
    output stall_o, flush_o, pc_sel_o, fwd_rs1_o, fwd_rs2_o, dmem_req_o, wb_we_o, wb_rd_o
  );
endinterface

// File: rtl/pipe_hzd.sv
// Combinational hazard detect: classifies the MEM/WB instruction as a register
// writer and matches each ID/EX source register against its destination.
module pipe_hzd
  import pipe_ctrl_pkg::*;
(
  input  logic       wb_valid,
  input  logic [6:0] wb_op,
  input  logic [4:0] wb_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       wb_wr,
  output logic       match1,
  output logic       match2
);

  logic [4:0] src [2];
  logic [1:0] hit;

  assign wb_wr  = is_writer(wb_op) & (wb_rd != 5'd0);
  assign src[0] = rs1;
  assign src[1] = rs2;

  // x0 is hardwired to zero, so it can never be a true dependency
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = wb_valid & wb_wr & (src[gi] == wb_rd) & (src[gi] != 5'd0);
    end
  endgenerate

  assign match1 = hit[0];
  assign match2 = hit[1];

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencer for the IF | ID/EX | MEM/WB pipeline.
// Define PIPE_CTRL_FWD_EN to forward the WB result instead of stalling on RAW.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_SLOTS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  pipe_ctrl_if.slave  bus
);

  localparam int CW = $clog2(FLUSH_SLOTS + 1);

  pipe_state_e    state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           wb_valid_reg;
  logic [6:0]     wb_op_reg;
  logic [4:0]     wb_rd_reg;

  logic wb_wr;
  logic match1;
  logic match2;
  logic dmem_req;
  logic mem_stall;
  logic in_redirect;
  logic take_br;
  logic raw_stall;

  pipe_hzd u_hzd (
    .wb_valid (wb_valid_reg),
    .wb_op    (wb_op_reg),
    .wb_rd    (wb_rd_reg),
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .wb_wr    (wb_wr),
    .match1   (match1),
    .match2   (match2)
  );

  assign dmem_req    = wb_valid_reg & is_mem(wb_op_reg);
  assign mem_stall   = dmem_req & ~bus.dmem_ready_i;
  assign in_redirect = (state_reg == REDIRECT);
  // A held ID/EX branch is re-presented, so it only redirects once memory is done
  assign take_br     = ~in_redirect & ~mem_stall & bus.br_taken_i & bus.id_valid_i;

`ifdef PIPE_CTRL_FWD_EN
  assign raw_stall     = 1'b0;
  assign bus.fwd_rs1_o = match1;
  assign bus.fwd_rs2_o = match2;
`else
  assign raw_stall     = ~in_redirect & ~mem_stall & ~take_br & bus.id_valid_i & (match1 | match2);
  assign bus.fwd_rs1_o = 1'b0;
  assign bus.fwd_rs2_o = 1'b0;
`endif

  // Gated by rst_ni so a taken branch presented during reset cannot leak out
  assign bus.stall_o    = rst_ni & (mem_stall | raw_stall);
  assign bus.flush_o    = rst_ni & (take_br | in_redirect);
  assign bus.pc_sel_o   = rst_ni & take_br;
  assign bus.dmem_req_o = dmem_req;
  assign bus.wb_we_o    = wb_valid_reg & wb_wr & (~dmem_req | bus.dmem_ready_i);
  assign bus.wb_rd_o    = wb_rd_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      wb_valid_reg <= 1'b0;
      wb_op_reg    <= 7'd0;
      wb_rd_reg    <= 5'd0;
    end else begin
      unique case (state_reg)
        REDIRECT: begin
          wb_valid_reg <= 1'b0;
          wb_op_reg    <= bus.id_op_i;
          wb_rd_reg    <= bus.id_rd_i;
          if (cnt_reg <= CW'(1)) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          // RUN and MEM_WAIT share advance rules; MEM_WAIT just means ready is pending
          if (mem_stall) begin
            state_reg <= MEM_WAIT;
          end else begin
            wb_valid_reg <= bus.id_valid_i & ~raw_stall;
            wb_op_reg    <= bus.id_op_i;
            wb_rd_reg    <= bus.id_rd_i;
            if (take_br && (FLUSH_SLOTS > 1)) begin
              state_reg <= REDIRECT;
              cnt_reg   <= CW'(FLUSH_SLOTS - 1);
            end else begin
              state_reg <= RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Cycle-table bench for pipe_ctrl: per-cycle control vectors and write-back
// destinations are queued at stimulus time and compared when the DUT responds.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  pipe_ctrl_if bus();

  pipe_ctrl #(.FLUSH_SLOTS(2)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] exp_q [$];
  int         wb_q  [$];

  localparam logic [6:0] Z = 7'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Vector order: stall, flush, pc_sel, fwd1, fwd2, dmem_req, wb_we
  function automatic logic [6:0] ev(input logic s, input logic f, input logic p,
                                    input logic f1, input logic f2,
                                    input logic rq, input logic we);
    return {s, f, p, f1, f2, rq, we};
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic v, input logic [6:0] op,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic br, input logic rdy, input logic [6:0] e, input int push_rd);
    logic [6:0] obs;
    logic [6:0] exp_v;
    int         rd_exp;
    rst_n            = rst;
    bus.id_valid_i   = v;
    bus.id_op_i      = op;
    bus.id_rs1_i     = r1;
    bus.id_rs2_i     = r2;
    bus.id_rd_i      = rd;
    bus.br_taken_i   = br;
    bus.dmem_ready_i = rdy;
    exp_q.push_back(e);
    if (push_rd >= 0) wb_q.push_back(push_rd);
    @(negedge clk);
    obs   = {bus.stall_o, bus.flush_o, bus.pc_sel_o, bus.fwd_rs1_o, bus.fwd_rs2_o,
             bus.dmem_req_o, bus.wb_we_o};
    exp_v = exp_q.pop_front();
    $display("%-10s ctl=%b wb_rd=%0d", tag, obs, bus.wb_rd_o);
    chk(tag, int'(obs), int'(exp_v));
    if (!rst) chk({tag, "_rd"}, int'(bus.wb_rd_o), 0);
    if (bus.wb_we_o) begin
      chk({tag, "_wbq"}, int'(wb_q.size() > 0), 1);
      if (wb_q.size() > 0) begin
        rd_exp = wb_q.pop_front();
        chk({tag, "_wbrd"}, int'(bus.wb_rd_o), rd_exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.id_valid_i   = 1'b0;
    bus.id_op_i      = 7'd0;
    bus.id_rs1_i     = 5'd0;
    bus.id_rs2_i     = 5'd0;
    bus.id_rd_i      = 5'd0;
    bus.br_taken_i   = 1'b0;
    bus.dmem_ready_i = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    cyc("rst0",  0, 0, 7'd0, 0, 0, 0, 0, 0, Z, -1);
    cyc("rst1",  0, 1, JAL,  0, 0, 1, 1, 1, Z, -1);
    cyc("idle",  1, 0, 7'd0, 0, 0, 0, 0, 0, Z, -1);

    // ADD x5 ; SUB x6,x5,x1
    cyc("add_x5", 1, 1, ALU_REG, 1, 2, 5, 0, 0, Z, 5);
`ifdef PIPE_CTRL_FWD_EN
    cyc("sub_fwd", 1, 1, ALU_REG, 5, 1, 6, 0, 0, ev(0,0,0,1,0,0,1), 6);
    cyc("sub_wb",  1, 0, 7'd0,    0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1), -1);
`else
    cyc("sub_raw", 1, 1, ALU_REG, 5, 1, 6, 0, 0, ev(1,0,0,0,0,0,1), -1);
    cyc("sub_go",  1, 1, ALU_REG, 5, 1, 6, 0, 0, Z, 6);
    cyc("sub_wb",  1, 0, 7'd0,    0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1), -1);
`endif

    // LW x8 ; ADD x9,x1,x8 with memory ready at once (rs2 path)
    cyc("lw_x8", 1, 1, LOAD, 1, 0, 8, 0, 0, Z, 8);
`ifdef PIPE_CTRL_FWD_EN
    cyc("use_fwd", 1, 1, ALU_REG, 1, 8, 9, 0, 1, ev(0,0,0,0,1,1,1), 9);
    cyc("use_wb",  1, 0, 7'd0,    0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1), -1);
`else
    cyc("use_raw", 1, 1, ALU_REG, 1, 8, 9, 0, 1, ev(1,0,0,0,0,1,1), -1);
    cyc("use_go",  1, 1, ALU_REG, 1, 8, 9, 0, 0, Z, 9);
    cyc("use_wb",  1, 0, 7'd0,    0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1), -1);
`endif

    // LW x3 with three not-ready cycles; ready while idle must be ignored
    cyc("lw_x3", 1, 1, LOAD, 1, 0, 3, 0, 1, Z, 3);
    for (int i = 0; i < 3; i++)
      cyc("lw_wait", 1, 1, ALU_REG, 1, 2, 7, 0, 0, ev(1,0,0,0,0,1,0), -1);
    cyc("lw_ready", 1, 1, ALU_REG, 1, 2, 7, 0, 1, ev(0,0,0,0,0,1,1), 7);
    cyc("add7_wb",  1, 0, 7'd0,    0, 0, 0, 0, 1, ev(0,0,0,0,0,0,1), -1);

    // taken BEQ: two flush cycles, flushed writer never writes back
    cyc("beq",    1, 1, BRANCH,  1, 2, 0, 1, 0, ev(0,1,1,0,0,0,0), -1);
    cyc("flush2", 1, 1, ALU_REG, 1, 2, 9, 1, 0, ev(0,1,0,0,0,0,0), -1);
    cyc("post1",  1, 0, 7'd0,    0, 0, 0, 0, 0, Z, -1);
    cyc("post2",  1, 0, 7'd0,    0, 0, 0, 0, 0, Z, -1);

    // ADDI x0,x0,1 ; ADD x1,x0,x0
    cyc("addi_x0",   1, 1, ALU_IMM, 0, 0, 0, 0, 0, Z, -1);
    cyc("add_x1",    1, 1, ALU_REG, 0, 0, 1, 0, 0, Z, 1);
    cyc("add_x1_wb", 1, 0, 7'd0,    0, 0, 0, 0, 0, ev(0,0,0,0,0,0,1), -1);

    // SW waiting on memory while a taken JAL sits in ID/EX
    cyc("sw",        1, 1, STORE, 1, 2, 0, 0, 0, Z, -1);
    cyc("jal_hold",  1, 1, JAL,   0, 0, 1, 1, 0, ev(1,0,0,0,0,1,0), -1);
    cyc("jal_hold",  1, 1, JAL,   0, 0, 1, 1, 0, ev(1,0,0,0,0,1,0), -1);
    cyc("jal_go",    1, 1, JAL,   0, 0, 1, 1, 1, ev(0,1,1,0,0,1,0), 1);
    cyc("jal_flush", 1, 0, 7'd0,  0, 0, 0, 0, 0, ev(0,1,0,0,0,0,1), -1);
    cyc("jal_post",  1, 0, 7'd0,  0, 0, 0, 0, 0, Z, -1);

    // reset during MEM_WAIT abandons the access
    cyc("lw_x4",    1, 1, LOAD, 1, 0, 4, 0, 0, Z, -1);
    cyc("lw4_wait", 1, 0, 7'd0, 0, 0, 0, 0, 0, ev(1,0,0,0,0,1,0), -1);
    cyc("rst_mid",  0, 1, JAL,  0, 0, 2, 1, 0, Z, -1);
    cyc("lw_x4b",   1, 1, LOAD, 1, 0, 4, 0, 0, Z, 4);
    cyc("lw4b_rdy", 1, 0, 7'd0, 0, 0, 0, 0, 1, ev(0,0,0,0,0,1,1), -1);
    cyc("end",      1, 0, 7'd0, 0, 0, 0, 0, 0, Z, -1);

    chk("wbq_drain", wb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
